mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported memory between the IF stage (instruction fetch) and the MEM stage
//   (lw/lb/sw/sb/lwn/swn). Arbitrates, sequences multi-cycle reads, returns data, and drives the
//   stall signals the pipeline uses to freeze IF/ID and EX/MEM while a requester waits.
// PARAMETERS
//   ADDR_W        32  address width
//   DATA_W        32  data width
//   MEM_LATENCY   2   cycles from read issue (mem_en) to mem_rdata valid; legal range 1..15
//   STARVE_LIMIT  4   consecutive MEM grants with IF waiting before IF is forced; legal range 1..15
// PORTS
//   clk         in   1       single clock, all state updates on rising edge
//   rst_n       in   1       synchronous reset, active low
//   if_req      in   1       IF read request, held until if_rvalid
//   if_addr     in   ADDR_W  IF read address (program counter)
//   if_gnt      out  1       1-cycle pulse: IF request issued to memory
//   if_rvalid   out  1       1-cycle pulse: if_rdata valid
//   if_rdata    out  DATA_W  instruction word
//   dm_req      in   1       MEM stage request, held until dm_gnt (write) or dm_rvalid (read)
//   dm_rw       in   2       01 = read, 10 = write; 00/11 = no request
//   dm_addr     in   ADDR_W  data address (ALU result)
//   dm_wdata    in   DATA_W  store data
//   dm_byte     in   1       1 = byte access, 0 = word
//   dm_gnt      out  1       1-cycle pulse: MEM request issued
//   dm_rvalid   out  1       1-cycle pulse: dm_rdata valid
//   dm_rdata    out  DATA_W  load data
//   mem_en      out  1       memory strobe, 1 cycle per access
//   mem_we      out  1       memory write enable, qualified by mem_en
//   mem_addr    out  ADDR_W  memory address
//   mem_wdata   out  DATA_W  memory write data
//   mem_byte    out  1       byte/word select to memory
//   mem_rdata   in   DATA_W  memory read data, valid MEM_LATENCY cycles after read issue
//   stall_if    out  1       IF request pending and not completing this cycle
//   stall_mem   out  1       MEM request pending and not completing this cycle
// BEHAVIOUR
//   - Reset (rst_n = 0 at posedge): state IDLE, latency counter 0, starve counter 0, owner
//     cleared; all registered outputs 0 (gnt, rvalid, rdata, mem_en, mem_we, mem_addr,
//     mem_wdata, mem_byte). Reset mid-read aborts it: no rvalid is produced.
//   - Stalls are combinational: stall_if = if_req & ~if_rvalid;
//     stall_mem = dm_req_valid & ~dm_rvalid & ~(write grant this cycle).
//   - dm_req_valid = dm_req & (dm_rw == 01 | dm_rw == 10); other dm_rw values are ignored.
//   - FSM states: IDLE, RD_WAIT.
//   - IDLE arbitration (registered decision, issue in the same cycle):
//       both pending: MEM wins unless starve_cnt == STARVE_LIMIT, then IF wins; else sole requester.
//   - Issue cycle: mem_en = 1, address/controls of winner on mem_*, winner's gnt = 1.
//       write: mem_we = 1, transaction completes this cycle, stay IDLE (back-to-back legal).
//       read:  mem_we = 0, latch owner, lat_cnt <= MEM_LATENCY, go RD_WAIT.
//   - RD_WAIT: mem_en = 0; lat_cnt decrements each cycle; when it hits 0, capture mem_rdata into the
//     owner's rdata, pulse the owner's rvalid for 1 cycle, return to IDLE. Latency is
//     MEM_LATENCY + 1 cycles from gnt to rvalid. No new issue is possible in RD_WAIT.
//     Next arbitration is in the cycle after rvalid.
//   - rdata holds its value until the next read completion for the same requester.
//   - Request dropped while in RD_WAIT: transaction still completes, rvalid still pulses (ignored).
//   - Starve counter: +1 on each MEM grant while if_req = 1 (saturates at STARVE_LIMIT);
//     cleared on IF grant or whenever if_req = 0.
//   - Requests arriving in RD_WAIT are held by the requester and arbitrated in the next IDLE.
// TESTING
//   1. IF only, if_addr=0x0040, MEM_LATENCY=2: if_gnt at cycle t, mem_en=1 addr=0x0040,
//      if_rvalid at t+3 with if_rdata=mem_rdata; stall_if=1 from t until t+3.
//   2. MEM write only, dm_rw=10, addr=0x100, wdata=0xDEADBEEF, dm_byte=0: dm_gnt,
//      mem_en=1, mem_we=1 in the same cycle; stall_mem=0 that cycle; 3 writes back-to-back.
//   3. Both requesting reads every cycle, STARVE_LIMIT=4: grant order MEM,MEM,MEM,MEM,IF,MEM...
//   4. Reset asserted in RD_WAIT 1 cycle after gnt: no rvalid ever; all outputs 0;
//      first post-reset request is served normally.
//   5. dm_req=1 with dm_rw=11 while if_req=1: IF granted, stall_mem=0, dm_gnt never pulses.
//   6. MEM_LATENCY=1 vs 15: rvalid exactly 2 and 16 cycles after gnt; byte read
//      (dm_byte=1) drives mem_byte=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and the MEM stage.
// Issues one access per cycle in IDLE, sequences reads through RD_WAIT, drives pipeline stalls.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [1:0]        dm_rw,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_byte,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_byte,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t            state, state_d;
    logic [3:0]        lat_cnt, lat_d;
    logic [3:0]        starve_cnt, starve_d;
    logic              owner_if, owner_d;

    logic              if_gnt_d, dm_gnt_d, if_rvalid_d, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_d, dm_rdata_d;
    logic              mem_en_d, mem_we_d, mem_byte_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    logic              dm_req_valid, dm_is_write, pick_if, pick_dm;

    assign dm_req_valid = dm_req & ((dm_rw == 2'b01) | (dm_rw == 2'b10));
    assign dm_is_write  = (dm_rw == 2'b10);

    // MEM has priority until IF has watched STARVE_LIMIT MEM grants go by.
    assign pick_if = if_req & (~dm_req_valid | (starve_cnt == 4'(STARVE_LIMIT)));
    assign pick_dm = dm_req_valid & ~pick_if;

    assign stall_if  = if_req & ~if_rvalid;
    assign stall_mem = dm_req_valid & ~dm_rvalid & ~(dm_gnt & mem_we);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_if   <= 1'b0;
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_byte   <= 1'b0;
        end else begin
            state      <= state_d;
            lat_cnt    <= lat_d;
            starve_cnt <= starve_d;
            owner_if   <= owner_d;
            if_gnt     <= if_gnt_d;
            dm_gnt     <= dm_gnt_d;
            if_rvalid  <= if_rvalid_d;
            dm_rvalid  <= dm_rvalid_d;
            if_rdata   <= if_rdata_d;
            dm_rdata   <= dm_rdata_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_byte   <= mem_byte_d;
        end
    end

    always_comb begin
        state_d     = state;
        lat_d       = lat_cnt;
        starve_d    = starve_cnt;
        owner_d     = owner_if;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_byte_d  = mem_byte;

        case (state)
            IDLE: begin
                if (pick_if) begin
                    if_gnt_d   = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = if_addr;
                    mem_byte_d = 1'b0;
                    owner_d    = 1'b1;
                    lat_d      = 4'(MEM_LATENCY);
                    state_d    = RD_WAIT;
                    starve_d   = '0;
                end else if (pick_dm) begin
                    dm_gnt_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_is_write;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_byte_d  = dm_byte;
                    if (starve_cnt != 4'(STARVE_LIMIT)) begin
                        starve_d = starve_cnt + 4'd1;
                    end
                    if (!dm_is_write) begin
                        owner_d = 1'b0;
                        lat_d   = 4'(MEM_LATENCY);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt == '0) begin
                    if (owner_if) begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end else begin
                        dm_rdata_d  = mem_rdata;
                        dm_rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    lat_d = lat_cnt - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!if_req) begin
            starve_d = '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected issues/returns queued at stimulus time,
// popped by a negedge monitor; two extra instances cover the latency extremes.
module tb_mem_port_arbiter;

    localparam int MAIN_LAT = 2;

    typedef struct {
        bit          is_if;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          byt;
    } iss_t;

    typedef struct {
        bit          is_if;
        int          due;
        logic [31:0] data;
    } rv_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_byte, dm_gnt, dm_rvalid;
    logic [1:0]  dm_rw;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we, mem_byte;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mem;

    // Latency-extreme instances: [0] MEM_LATENCY=1, [1] MEM_LATENCY=15
    logic        x_req [2];
    logic        x_if_gnt [2], x_if_rv [2], x_dm_gnt [2], x_dm_rv [2];
    logic [31:0] x_if_rdata [2], x_dm_rdata [2], x_addr [2], x_wdata [2];
    logic        x_en [2], x_we [2], x_byte [2], x_st_if [2], x_st_mem [2];
    logic [31:0] x_mrd;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    iss_t exp_iss[$];
    rv_t  exp_rv[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read data encodes the cycle it was presented, so the capture cycle is observable.
    assign mem_rdata = 32'hA000_0000 | 32'(cyc);
    assign x_mrd     = 32'hC000_0000 | 32'(cyc);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(MAIN_LAT), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_byte(dm_byte),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte(mem_byte), .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(1'b0), .if_addr(32'h0), .if_gnt(x_if_gnt[0]), .if_rvalid(x_if_rv[0]), .if_rdata(x_if_rdata[0]),
        .dm_req(x_req[0]), .dm_rw(2'b01), .dm_addr(32'h0000_0500), .dm_wdata(32'h0), .dm_byte(1'b1),
        .dm_gnt(x_dm_gnt[0]), .dm_rvalid(x_dm_rv[0]), .dm_rdata(x_dm_rdata[0]),
        .mem_en(x_en[0]), .mem_we(x_we[0]), .mem_addr(x_addr[0]), .mem_wdata(x_wdata[0]),
        .mem_byte(x_byte[0]), .mem_rdata(x_mrd), .stall_if(x_st_if[0]), .stall_mem(x_st_mem[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(15), .STARVE_LIMIT(4)) u_lat15 (
        .clk(clk), .rst_n(rst_n),
        .if_req(1'b0), .if_addr(32'h0), .if_gnt(x_if_gnt[1]), .if_rvalid(x_if_rv[1]), .if_rdata(x_if_rdata[1]),
        .dm_req(x_req[1]), .dm_rw(2'b01), .dm_addr(32'h0000_0500), .dm_wdata(32'h0), .dm_byte(1'b1),
        .dm_gnt(x_dm_gnt[1]), .dm_rvalid(x_dm_rv[1]), .dm_rdata(x_dm_rdata[1]),
        .mem_en(x_en[1]), .mem_we(x_we[1]), .mem_addr(x_addr[1]), .mem_wdata(x_wdata[1]),
        .mem_byte(x_byte[1]), .mem_rdata(x_mrd), .stall_if(x_st_if[1]), .stall_mem(x_st_mem[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_iss(input bit is_if, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit byt);
        iss_t it;
        it.is_if = is_if;
        it.we    = we;
        it.addr  = addr;
        it.wdata = wdata;
        it.byt   = byt;
        exp_iss.push_back(it);
    endtask

    // Monitor: every memory issue and every read return is checked against the queues.
    always @(negedge clk) begin
        iss_t it;
        rv_t  r;
        bit   exp_wg, exp_if_rv, exp_dm_rv, dm_valid;
        if (mon_en) begin
            exp_wg    = 1'b0;
            exp_if_rv = 1'b0;
            exp_dm_rv = 1'b0;
            if (mem_en || if_gnt || dm_gnt) begin
                if (exp_iss.size() == 0) begin
                    check("unexpected_issue", {61'd0, mem_en, if_gnt, dm_gnt}, 64'd0);
                end else begin
                    it = exp_iss.pop_front();
                    check("mem_en", mem_en, 1);
                    check("if_gnt", if_gnt, it.is_if);
                    check("dm_gnt", dm_gnt, !it.is_if);
                    check("mem_addr", mem_addr, it.addr);
                    check("mem_we", mem_we, it.we);
                    check("mem_byte", mem_byte, it.byt);
                    if (it.we) begin
                        check("mem_wdata", mem_wdata, it.wdata);
                    end else begin
                        r.is_if = it.is_if;
                        r.due   = cyc + MAIN_LAT + 1;
                        r.data  = 32'hA000_0000 | 32'(cyc + MAIN_LAT);
                        exp_rv.push_back(r);
                    end
                    exp_wg = it.we && !it.is_if;
                end
            end
            if (exp_rv.size() != 0 && exp_rv[0].due <= cyc) begin
                r = exp_rv.pop_front();
                exp_if_rv = r.is_if;
                exp_dm_rv = !r.is_if;
                check("if_rvalid", if_rvalid, r.is_if);
                check("dm_rvalid", dm_rvalid, !r.is_if);
                if (r.is_if) check("if_rdata", if_rdata, r.data);
                else         check("dm_rdata", dm_rdata, r.data);
            end else if (if_rvalid || dm_rvalid) begin
                check("spurious_rvalid", {62'd0, if_rvalid, dm_rvalid}, 64'd0);
            end
            dm_valid = dm_req && (dm_rw == 2'b01 || dm_rw == 2'b10);
            check("stall_if", stall_if, if_req && !exp_if_rv);
            check("stall_mem", stall_mem, dm_valid && !exp_dm_rv && !exp_wg);
        end
    end

    task automatic if_read(input logic [31:0] addr);
        bit done = 1'b0;
        if_addr = addr;
        if_req  = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #1;
            if (if_rvalid) done = 1'b1;
        end
        if_req = 1'b0;
        if (!done) check("if_timeout", 0, 1);
    endtask

    task automatic dm_op(input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic byt, output int gc);
        bit done = 1'b0;
        gc = -1;
        dm_rw    = rw;
        dm_addr  = addr;
        dm_wdata = wdata;
        dm_byte  = byt;
        dm_req   = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #1;
            if (dm_gnt) gc = cyc;
            if (rw == 2'b10 ? dm_gnt : dm_rvalid) done = 1'b1;
        end
        dm_req = 1'b0;
        dm_rw  = 2'b00;
        if (!done) check("dm_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_iss.size() == 0 && exp_rv.size() == 0) break;
            @(negedge clk);
        end
        check("drain_iss", exp_iss.size(), 0);
        check("drain_rv", exp_rv.size(), 0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_if_gnt"}, if_gnt, 0);
        check({pfx, "_dm_gnt"}, dm_gnt, 0);
        check({pfx, "_if_rvalid"}, if_rvalid, 0);
        check({pfx, "_dm_rvalid"}, dm_rvalid, 0);
        check({pfx, "_if_rdata"}, if_rdata, 0);
        check({pfx, "_dm_rdata"}, dm_rdata, 0);
        check({pfx, "_mem_en"}, mem_en, 0);
        check({pfx, "_mem_we"}, mem_we, 0);
        check({pfx, "_mem_addr"}, mem_addr, 0);
        check({pfx, "_mem_wdata"}, mem_wdata, 0);
        check({pfx, "_mem_byte"}, mem_byte, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int g0, g1, g2, gd;
        int xg [2];
        int xr [2];
        int xl [2];
        bit xdone [2];

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_rw = 2'b00; dm_addr = '0; dm_wdata = '0; dm_byte = 1'b0;
        x_req[0] = 1'b0; x_req[1] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk); #1;

        // IF-only read
        push_iss(1, 0, 32'h0000_0040, 0, 0);
        if_read(32'h0000_0040);
        drain();

        // three back-to-back word writes
        push_iss(0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0);
        push_iss(0, 1, 32'h0000_0104, 32'h1234_5678, 0);
        push_iss(0, 1, 32'h0000_0108, 32'hCAFE_F00D, 0);
        dm_op(2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, g0);
        dm_op(2'b10, 32'h0000_0104, 32'h1234_5678, 1'b0, g1);
        dm_op(2'b10, 32'h0000_0108, 32'hCAFE_F00D, 1'b0, g2);
        check("wr_b2b_1", g1 - g0, 1);
        check("wr_b2b_2", g2 - g1, 1);
        drain();

        // contention: MEM x4, IF (starved), MEM x2, IF
        for (int i = 0; i < 4; i++) push_iss(0, 0, 32'h0000_0200 + 32'(4 * i), 0, 0);
        push_iss(1, 0, 32'h0000_1000, 0, 0);
        push_iss(0, 0, 32'h0000_0210, 0, 0);
        push_iss(0, 0, 32'h0000_0214, 0, 0);
        push_iss(1, 0, 32'h0000_1004, 0, 0);
        fork
            begin
                int gc;
                for (int i = 0; i < 6; i++) dm_op(2'b01, 32'h0000_0200 + 32'(4 * i), 0, 1'b0, gc);
            end
            begin
                if_read(32'h0000_1000);
                if_read(32'h0000_1004);
            end
        join
        drain();

        // dm_rw=11 is no request: IF granted, no stall_mem, no dm_gnt
        push_iss(1, 0, 32'h0000_0300, 0, 0);
        dm_req = 1'b1;
        dm_rw  = 2'b11;
        if_read(32'h0000_0300);
        dm_req = 1'b0;
        dm_rw  = 2'b00;
        drain();

        // byte read and byte write
        push_iss(0, 0, 32'h0000_0401, 0, 1);
        dm_op(2'b01, 32'h0000_0401, 0, 1'b1, gd);
        push_iss(0, 1, 32'h0000_0402, 32'h0000_0055, 1);
        dm_op(2'b10, 32'h0000_0402, 32'h0000_0055, 1'b1, gd);
        drain();

        // reset one cycle after an IF grant aborts the read
        push_iss(1, 0, 32'h0000_0080, 0, 0);
        if_addr = 32'h0000_0080;
        if_req  = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk); #1;
                if (if_gnt) seen = 1'b1;
            end
            if (!seen) check("rst_gnt_timeout", 0, 1);
        end
        @(negedge clk); #1;
        rst_n  = 1'b0;
        if_req = 1'b0;
        exp_rv.delete();
        @(negedge clk); #1;
        check_outputs_zero("midrd_reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("no_rvalid_after_reset", exp_rv.size(), 0);
        push_iss(1, 0, 32'h0000_0084, 0, 0);
        if_read(32'h0000_0084);
        drain();

        // latency extremes on the side instances
        xl[0] = 1;
        xl[1] = 15;
        for (int k = 0; k < 2; k++) begin
            xg[k] = -1;
            xr[k] = -1;
            xdone[k] = 1'b0;
            x_req[k] = 1'b1;
        end
        for (int c = 0; c < 40 && !(xdone[0] && xdone[1]); c++) begin
            @(negedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (x_dm_gnt[k] && x_req[k]) begin
                    xg[k] = cyc;
                    check("lat_mem_byte", x_byte[k], 1);
                    check("lat_mem_addr", x_addr[k], 32'h0000_0500);
                end
                if (x_dm_rv[k] && x_req[k]) begin
                    xr[k] = cyc;
                    xdone[k] = 1'b1;
                    x_req[k] = 1'b0;
                    check("lat_rdata", x_dm_rdata[k], 32'hC000_0000 | 32'(xg[k] + xl[k]));
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            x_req[k] = 1'b0;
            check("lat_done", xdone[k], 1);
            check("lat_cycles", xr[k] - xg[k], xl[k] + 1);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
